// File: rtl/indicator_7_scan_if.sv
// indicator_7_scan_if: load/data and display-pin bundle for indicator_7_scan.
// master = display-data source, slave = the scan driver.
interface indicator_7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   codes;
  logic [DIGITS-1:0]     blink_mask;
  logic [6:0]            segments;
  logic [DIGITS-1:0]     digit_en;
  logic                  frame_start;

  modport master (
    output load, codes, blink_mask,
    input  segments, digit_en, frame_start
  );

  modport slave (
    input  load, codes, blink_mask,
    output segments, digit_en, frame_start
  );
endinterface

// File: rtl/indicator_7_scan.sv
// indicator_7_scan: multiplexed 7-segment driver.
// Shadow-latches DIGITS 4-bit codes on load, scans digits one-hot for SCAN_DIV
// cycles each, and maps code[2:0] through the indicator pattern table.
// Optional blink (macro INDICATOR_BLINK_EN): every BLINK_DIV frames a phase
// flips; in phase 1, digits whose shadow mask bit is set show blank segments.
module indicator_7_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input logic               clk,
  input logic               rst_n,
  indicator_7_scan_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [DIGITS-1:0][3:0] code_sh;
  logic [PW-1:0]          pre;
  logic [IW-1:0]          idx;
  logic                   slot_end, frame_end, blank;
  logic [6:0]             pat;
  logic [6:0]             seg_q;
  logic [DIGITS-1:0]      en_q;
  logic                   fs_q;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Shadow code register: replaced wholesale on every load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        code_sh <= '0;
    else if (bus.load) code_sh <= bus.codes;
  end

  // Prescaler and digit index; load never touches these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= slot_end ? '0 : pre + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

`ifdef INDICATOR_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_DIV - 1);

  logic [DIGITS-1:0] mask_sh;
  logic [FW-1:0]     fcnt;
  logic              phase;

  // Shadow blink mask, captured alongside the codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mask_sh <= '0;
    else if (bus.load) mask_sh <= bus.blink_mask;
  end

  // Frame counter steps on the edge that enters a digit-0 slot, so a new
  // phase is already in force for the first displayed cycle of that frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FR_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blank = phase & mask_sh[idx];
`else
  assign blank = 1'b0;
`endif

  // Pattern table lookup; codes 8..15 alias onto 0..7.
  always_comb begin
    pat = 7'b0000000;
    case (code_sh[idx][2:0])
      3'd0: pat = 7'b0000000;
      3'd1: pat = 7'b0101010;
      3'd2: pat = 7'b1010101;
      3'd3: pat = 7'b1110000;
      3'd4: pat = 7'b0001111;
      3'd5: pat = 7'b1100011;
      3'd6: pat = 7'b0011100;
      3'd7: pat = 7'b1111111;
      default: pat = 7'b0000000;
    endcase
  end

  // Registered outputs from the current index/shadow: no blanking gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= blank ? 7'b0000000 : pat;
      en_q  <= DIGITS'(1) << idx;
      fs_q  <= (idx == '0) && (pre == '0);
    end
  end

  assign bus.segments    = seg_q;
  assign bus.digit_en    = en_q;
  assign bus.frame_start = fs_q;
endmodule
